// File: rtl/ram_1r1w_sync_clr.sv
// ram_1r1w_sync_clr
//
// Single-clock 1-read/1-write synchronous RAM with per-lane write masks,
// write-first forwarding on same-address collisions, a read-valid output
// and a hardware clear engine that walks every entry after reset or on
// request (clear_i).
//
// Parameters:
//   width_p       data width in bits (multiple of gran_p)
//   depth_p       number of entries (any value >= 2)
//   gran_p        bits per write-mask lane
//   clear_value_p value written to every entry by the clear engine
//
// Ports:
//   clk_i       clock, all logic on posedge
//   reset_i     asynchronous active-high reset
//   clear_i     request a full clear pass (level sampled)
//   busy_o      high while the clear engine owns the array
//   wr_valid_i / wr_ready_o / wr_addr_i / wr_data_i / wr_mask_i
//               write request channel, accepted when valid & ready
//   rd_valid_i / rd_ready_o / rd_addr_i
//               read request channel, accepted when valid & ready
//   rd_valid_o  one-cycle pulse marking a read response on rd_data_o
//   rd_data_o   read data, holds its last value between responses
//
// Build option:
//   RAM_OUT_REG_EN  adds an output register stage (read latency 2 instead
//                   of 1). Forwarding is still resolved at accept time.

module ram_1r1w_sync_clr #(
    parameter int                 width_p       = 32,
    parameter int                 depth_p       = 512,
    parameter int                 gran_p        = 8,
    parameter logic [width_p-1:0] clear_value_p = '0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       clear_i,
    output logic                       busy_o,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic [$clog2(depth_p)-1:0] wr_addr_i,
    input  logic [width_p-1:0]         wr_data_i,
    input  logic [width_p/gran_p-1:0]  wr_mask_i,
    input  logic                       rd_valid_i,
    output logic                       rd_ready_o,
    input  logic [$clog2(depth_p)-1:0] rd_addr_i,
    output logic                       rd_valid_o,
    output logic [width_p-1:0]         rd_data_o
);

    localparam int lanes_c  = width_p / gran_p;
    localparam int addr_w_c = $clog2(depth_p);
    localparam logic [addr_w_c-1:0] last_addr_c = addr_w_c'(depth_p - 1);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t              state;
    logic [addr_w_c-1:0] clr_addr;

    logic [width_p-1:0]  mem [depth_p];

    logic                wr_fire;
    logic                rd_fire;
    logic                wr_in_range;
    logic                rd_in_range;
    logic                wr_hit;
    logic [width_p-1:0]  rd_word;

    logic                vld_p0;
    logic [width_p-1:0]  data_p0;

    // Handshakes only depend on registered ready flags, so no input reaches
    // an output combinationally.
    assign wr_fire = wr_valid_i & wr_ready_o;
    assign rd_fire = rd_valid_i & rd_ready_o;

    // With a power-of-two depth every address is a real entry; otherwise
    // addresses past the end are accepted but never touch the array.
    if ((1 << addr_w_c) == depth_p) begin : g_pow2
        assign wr_in_range = 1'b1;
        assign rd_in_range = 1'b1;
    end else begin : g_npow2
        localparam logic [addr_w_c:0] depth_c = (addr_w_c + 1)'(depth_p);
        assign wr_in_range = ({1'b0, wr_addr_i} < depth_c);
        assign rd_in_range = ({1'b0, rd_addr_i} < depth_c);
    end

    assign wr_hit = wr_fire & wr_in_range & (wr_addr_i == rd_addr_i);

    // Control FSM: the ready/busy flags are registered alongside the state so
    // that they always equal (state == READY) / (state == CLEAR).
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= S_CLEAR;
            clr_addr   <= '0;
            busy_o     <= 1'b1;
            wr_ready_o <= 1'b0;
            rd_ready_o <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clear_i) begin
                        // A new request while clearing restarts the pass.
                        clr_addr <= '0;
                    end else if (clr_addr == last_addr_c) begin
                        state      <= S_READY;
                        clr_addr   <= '0;
                        busy_o     <= 1'b0;
                        wr_ready_o <= 1'b1;
                        rd_ready_o <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                S_READY: begin
                    if (clear_i) begin
                        state      <= S_CLEAR;
                        clr_addr   <= '0;
                        busy_o     <= 1'b1;
                        wr_ready_o <= 1'b0;
                        rd_ready_o <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_CLEAR;
                    clr_addr   <= '0;
                    busy_o     <= 1'b1;
                    wr_ready_o <= 1'b0;
                    rd_ready_o <= 1'b0;
                end
            endcase
        end
    end

    // Storage array has no reset. The clear engine and user writes never
    // collide: user writes are only accepted in READY.
    always_ff @(posedge clk_i) begin
        if (state == S_CLEAR) begin
            mem[clr_addr] <= clear_value_p;
        end else if (wr_fire && wr_in_range) begin
            for (int k = 0; k < lanes_c; k++) begin
                if (wr_mask_i[k]) begin
                    mem[wr_addr_i][k*gran_p +: gran_p] <= wr_data_i[k*gran_p +: gran_p];
                end
            end
        end
    end

    // Read word with write-first forwarding, resolved in the accept cycle.
    always_comb begin
        rd_word = clear_value_p;
        if (rd_in_range) begin
            rd_word = mem[rd_addr_i];
            if (wr_hit) begin
                for (int k = 0; k < lanes_c; k++) begin
                    if (wr_mask_i[k]) begin
                        rd_word[k*gran_p +: gran_p] = wr_data_i[k*gran_p +: gran_p];
                    end
                end
            end
        end
    end

    // ---- stage p0: read response register ----
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else begin
            vld_p0 <= rd_fire;
            if (rd_fire) begin
                data_p0 <= rd_word;
            end
        end
    end

`ifdef RAM_OUT_REG_EN
    logic               vld_p1;
    logic [width_p-1:0] data_p1;

    // ---- stage p1: optional output register ----
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                data_p1 <= data_p0;
            end
        end
    end

    assign rd_valid_o = vld_p1;
    assign rd_data_o  = data_p1;
`else
    assign rd_valid_o = vld_p0;
    assign rd_data_o  = data_p0;
`endif

endmodule

// File: tb/tb_ram_1r1w_sync_clr.sv
// Self-checking bench for ram_1r1w_sync_clr.
// A depth-16 instance is tracked every cycle by a behavioural model (an
// array of words plus a count of remaining busy cycles); a depth-12
// instance covers out-of-range addresses.

module tb_ram_1r1w_sync_clr;

`ifdef RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam int          DEPTH16 = 16;
    localparam logic [31:0] CLR16   = 32'h5A5A_A5A5;
    localparam logic [31:0] CLR12   = 32'h0F0F_0F0F;

    logic clk;
    logic reset;

    // depth-16 instance signals
    logic        clear16;
    logic        busy16;
    logic        wr_valid16;
    logic        wr_ready16;
    logic [3:0]  wr_addr16;
    logic [31:0] wr_data16;
    logic [3:0]  wr_mask16;
    logic        rd_valid16;
    logic        rd_ready16;
    logic [3:0]  rd_addr16;
    logic        rd_vout16;
    logic [31:0] rd_data16;

    // depth-12 instance signals
    logic        clear12;
    logic        busy12;
    logic        wr_valid12;
    logic        wr_ready12;
    logic [3:0]  wr_addr12;
    logic [31:0] wr_data12;
    logic [3:0]  wr_mask12;
    logic        rd_valid12;
    logic        rd_ready12;
    logic [3:0]  rd_addr12;
    logic        rd_vout12;
    logic [31:0] rd_data12;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state for the depth-16 instance
    logic [31:0] ref_mem [DEPTH16];
    int          m_cnt;
    logic        pv [1:2];
    logic [31:0] pd [1:2];
    logic [31:0] hold;

    ram_1r1w_sync_clr #(
        .width_p(32), .depth_p(16), .gran_p(8), .clear_value_p(CLR16)
    ) u_dut16 (
        .clk_i(clk), .reset_i(reset), .clear_i(clear16), .busy_o(busy16),
        .wr_valid_i(wr_valid16), .wr_ready_o(wr_ready16), .wr_addr_i(wr_addr16),
        .wr_data_i(wr_data16), .wr_mask_i(wr_mask16),
        .rd_valid_i(rd_valid16), .rd_ready_o(rd_ready16), .rd_addr_i(rd_addr16),
        .rd_valid_o(rd_vout16), .rd_data_o(rd_data16)
    );

    ram_1r1w_sync_clr #(
        .width_p(32), .depth_p(12), .gran_p(8), .clear_value_p(CLR12)
    ) u_dut12 (
        .clk_i(clk), .reset_i(reset), .clear_i(clear12), .busy_o(busy12),
        .wr_valid_i(wr_valid12), .wr_ready_o(wr_ready12), .wr_addr_i(wr_addr12),
        .wr_data_i(wr_data12), .wr_mask_i(wr_mask12),
        .rd_valid_i(rd_valid12), .rd_ready_o(rd_ready12), .rd_addr_i(rd_addr12),
        .rd_valid_o(rd_vout12), .rd_data_o(rd_data12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle16();
        clear16    = 1'b0;
        wr_valid16 = 1'b0;
        rd_valid16 = 1'b0;
    endtask

    task automatic model_reset();
        m_cnt = DEPTH16;
        pv[1] = 1'b0;
        pv[2] = 1'b0;
        pd[1] = '0;
        pd[2] = '0;
        hold  = '0;
    endtask

    // One clock edge: apply the accepted write to the model, take the read
    // word (write-first falls out of reading after the write), advance the
    // clear counter, then compare every depth-16 output.
    task automatic tick();
        logic        acc_w;
        logic        acc_r;
        logic [31:0] rw;
        acc_w = wr_valid16 && (m_cnt == 0);
        acc_r = rd_valid16 && (m_cnt == 0);
        if (acc_w) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_mask16[k]) ref_mem[wr_addr16][k*8 +: 8] = wr_data16[k*8 +: 8];
            end
        end
        rw = ref_mem[rd_addr16];
        @(posedge clk);
        #1;
        if (clear16) begin
            m_cnt = DEPTH16;
        end else if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                for (int i = 0; i < DEPTH16; i++) ref_mem[i] = CLR16;
            end
        end
        pv[2] = pv[1];
        pd[2] = pd[1];
        pv[1] = acc_r;
        pd[1] = rw;
        if (pv[LAT]) hold = pd[LAT];
        check("busy", 32'(busy16), 32'(m_cnt != 0));
        check("wr_ready", 32'(wr_ready16), 32'(m_cnt == 0));
        check("rd_ready", 32'(rd_ready16), 32'(m_cnt == 0));
        check("rd_valid", 32'(rd_vout16), 32'(pv[LAT]));
        check("rd_data", rd_data16, hold);
    endtask

    task automatic read16(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        idle16();
        rd_valid16 = 1'b1;
        rd_addr16  = addr;
        tick();
        idle16();
        for (int j = 1; j < LAT; j++) tick();
        check(tag, rd_data16, exp);
    endtask

    task automatic write16(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] mask);
        idle16();
        wr_valid16 = 1'b1;
        wr_addr16  = addr;
        wr_data16  = data;
        wr_mask16  = mask;
        tick();
        idle16();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy16), 32'd1);
        check("rst_ready", 32'(rd_ready16), 32'd0);
        check("rst_rd_valid", 32'(rd_vout16), 32'd0);
        check("rst_rd_data", rd_data16, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_busy", 32'(busy16), 32'd1);
        reset = 1'b0;
        model_reset();
    endtask

    // Depth-12 read: valid must pulse exactly LAT cycles after accept.
    task automatic rd12(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        check({tag, "_ready"}, 32'(rd_ready12), 32'd1);
        rd_valid12 = 1'b1;
        rd_addr12  = addr;
        tick();
        rd_valid12 = 1'b0;
        for (int j = 1; j <= LAT; j++) begin
            if (j > 1) tick();
            check({tag, "_vld"}, 32'(rd_vout12), 32'(j == LAT));
        end
        tick();
        check({tag, "_vld_off"}, 32'(rd_vout12), 32'd0);
        check({tag, "_data"}, rd_data12, exp);
    endtask

    initial begin
        reset      = 1'b1;
        idle16();
        wr_addr16  = '0;
        wr_data16  = '0;
        wr_mask16  = '0;
        rd_addr16  = '0;
        clear12    = 1'b0;
        wr_valid12 = 1'b0;
        wr_addr12  = '0;
        wr_data12  = '0;
        wr_mask12  = '0;
        rd_valid12 = 1'b0;
        rd_addr12  = '0;
        model_reset();

        // Reset values, then the initial clear pass (16 / 12 busy cycles).
        repeat (2) @(posedge clk);
        #1;
        check("init_busy", 32'(busy16), 32'd1);
        check("init_wr_ready", 32'(wr_ready16), 32'd0);
        check("init_rd_valid", 32'(rd_vout16), 32'd0);
        check("init_rd_data", rd_data16, 32'd0);
        check("init_busy12", 32'(busy12), 32'd1);
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("busy12", 32'(busy12), 32'(k < 12));
            check("ready12", 32'(rd_ready12), 32'(k >= 12));
        end

        // Every entry reads back as the clear value.
        for (int a = 0; a < DEPTH16; a++) read16(4'(a), CLR16, "clr_read");

        // Masked writes.
        write16(4'd5, 32'hDEADBEEF, 4'b1111);
        write16(4'd5, 32'h11223344, 4'b0101);
        read16(4'd5, 32'hDE22BE44, "mask_merge");
        write16(4'd9, 32'h12345678, 4'b0000);
        read16(4'd9, CLR16, "mask_zero");

        // Collisions.
        write16(4'd3, 32'h12345678, 4'b1111);
        write16(4'd4, 32'h0BADF00D, 4'b1111);
        wr_valid16 = 1'b1; wr_addr16 = 4'd3; wr_data16 = 32'hAAAAAAAA; wr_mask16 = 4'b0011;
        rd_valid16 = 1'b1; rd_addr16 = 4'd3;
        tick();
        idle16();
        for (int j = 1; j < LAT; j++) tick();
        check("collide_fwd", rd_data16, 32'h1234AAAA);
        wr_valid16 = 1'b1; wr_addr16 = 4'd3; wr_data16 = 32'h55555555; wr_mask16 = 4'b1111;
        rd_valid16 = 1'b1; rd_addr16 = 4'd4;
        tick();
        idle16();
        for (int j = 1; j < LAT; j++) tick();
        check("collide_other", rd_data16, 32'h0BADF00D);
        read16(4'd3, 32'h55555555, "after_collide");

        // Back-to-back reads stream one response per cycle.
        rd_valid16 = 1'b1;
        for (int a = 3; a <= 5; a++) begin
            rd_addr16 = 4'(a);
            tick();
        end
        idle16();
        repeat (LAT) tick();

        // Write in the same cycle clear_i is sampled.
        wr_valid16 = 1'b1; wr_addr16 = 4'd9; wr_data16 = 32'hCAFEF00D; wr_mask16 = 4'b1111;
        clear16 = 1'b1;
        tick();
        idle16();
        repeat (DEPTH16) tick();
        read16(4'd9, CLR16, "clear_after_write");
        read16(4'd5, CLR16, "clear_other");

        // Out-of-range addresses on the depth-12 instance.
        check("oob_wr_ready", 32'(wr_ready12), 32'd1);
        wr_valid12 = 1'b1; wr_addr12 = 4'd13; wr_data12 = 32'h5; wr_mask12 = 4'b1111;
        tick();
        wr_valid12 = 1'b0;
        rd12(4'd13, CLR12, "oob13");
        rd12(4'd1, CLR12, "oob_alias1");
        rd12(4'd5, CLR12, "oob_alias5");
        wr_valid12 = 1'b1; wr_addr12 = 4'd11; wr_data12 = 32'h600DCAFE; wr_mask12 = 4'b1111;
        tick();
        wr_valid12 = 1'b0;
        rd12(4'd11, 32'h600DCAFE, "last12");

        // Randomised traffic, including occasional clear requests.
        for (int n = 0; n < 400; n++) begin
            wr_valid16 = 1'($urandom_range(0, 1));
            rd_valid16 = 1'($urandom_range(0, 1));
            wr_addr16  = 4'($urandom_range(0, 15));
            wr_data16  = $urandom;
            wr_mask16  = 4'($urandom_range(0, 15));
            rd_addr16  = ($urandom_range(0, 1) == 0) ? wr_addr16 : 4'($urandom_range(0, 15));
            clear16    = ($urandom_range(0, 59) == 0);
            tick();
        end
        idle16();
        repeat (DEPTH16 + 2) tick();

        // Reset in the middle of a read response.
        read16(4'd0, ref_mem[0], "pre_rst_read");
        rd_valid16 = 1'b1; rd_addr16 = 4'd2;
        tick();
        idle16();
        do_reset();
        repeat (DEPTH16 + 2) tick();

        // Reset at clear cycle 7: the pass restarts from the beginning.
        clear16 = 1'b1;
        tick();
        clear16 = 1'b0;
        repeat (7) tick();
        do_reset();
        repeat (DEPTH16 + 2) tick();
        read16(4'd15, CLR16, "post_rst_read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_1r1w_sync_clr.md
Name: ram_1r1w_sync_clr

Overview:
Single-clock, parametrised 1-read/1-write synchronous RAM. It is the next generation of the team's dual-clock sync RAM.
- Adds per-lane write masks and write-first forwarding on same-address read/write collisions.
- Adds a read-valid output.
- Adds a hardware clear engine that walks every entry after reset or on request.
- Used as storage under single-clock FIFOs and buffers whose contents must be deterministic after reset.

Parameters:
width_p, 32, data width in bits; must be a multiple of gran_p.
depth_p, 512, number of entries; need not be a power of two.
gran_p, 8, bits per write-mask lane; mask width is width_p/gran_p.
clear_value_p, '0, width_p-bit value written to every entry by the clear engine.

Ports:
clk_i  input  1  single clock; all logic on posedge
reset_i  input  1  asynchronous, active-high reset
clear_i  input  1  request a full clear pass (level sampled on clk_i)
busy_o  output  1  high while the clear engine owns the array
wr_valid_i  input  1  write request
wr_ready_o  output  1  write accepted when valid & ready
wr_addr_i  input  $clog2(depth_p)  write address
wr_data_i  input  width_p  write data
wr_mask_i  input  width_p/gran_p  per-lane write enable, 1 = lane written
rd_valid_i  input  1  read request
rd_ready_o  output  1  read accepted when valid & ready
rd_addr_i  input  $clog2(depth_p)  read address
rd_valid_o  output  1  one-cycle pulse, rd_data_o carries the response
rd_data_o  output  width_p  read data; holds its last value between responses

Behaviour:
- Reset (async assert): state=CLEAR, clr_addr=0, busy_o=1, rd_valid_o=0, rd_data_o=0, wr_ready_o=rd_ready_o=0.
- The array has no reset; the clear engine initialises it.
- FSM, two states:
  - CLEAR: each cycle writes clear_value_p to ram[clr_addr], then clr_addr++. On the cycle that writes depth_p-1, next state is READY. A full pass takes exactly depth_p cycles.
  - READY: normal operation. If clear_i=1, next state is CLEAR with clr_addr=0.
- clear_i asserted while in CLEAR: clr_addr restarts at 0 on the next cycle.
- busy_o = (state==CLEAR). wr_ready_o = rd_ready_o = (state==READY), registered; no combinational path from any input.
- Requests presented while ready=0 are dropped, not queued; the caller must hold them.
- Requests accepted in the same cycle clear_i is sampled complete normally:
  - the write lands before the clear pass overwrites it;
  - the read returns the pre-clear value.
- Write: on accept, for each lane k with wr_mask_i[k]=1, ram[addr][k*gran_p +: gran_p] <= the matching wr_data_i lane. Lanes with mask 0 are unchanged. A mask of all zeros is a legal no-op accept.
- Read: on accept at cycle N, rd_valid_o=1 and rd_data_o is valid at cycle N+1 (latency 1). rd_valid_o=0 in every cycle with no response. rd_data_o is not cleared on idle cycles.
- Collision, read and write accepted in the same cycle at the same address: write-first. Per lane, the response lane is wr_data_i if the mask bit is set, otherwise the old ram lane. Different addresses are independent.
- Addresses >= depth_p (non-power-of-two depth):
  - write: accepted and dropped;
  - read: accepted, responds with rd_valid_o=1 and rd_data_o=clear_value_p.
- Reset asserted mid-clear or mid-read: immediate return to the reset values; any pending response is discarded.

Optional Feature:
RAM_OUT_REG_EN.
- Defined: adds an output register stage. Read latency is 2: an accept at N gives rd_valid_o at N+2. Forwarding is resolved at accept time. rd_valid_o and the output stage reset to 0. Back-to-back reads stream one response per cycle.
- Not defined: latency 1 as described in Behaviour.

Test Plan:
- Reset release with depth_p=16 -> busy_o=1 for exactly 16 cycles. Ready rises on cycle 17. Reads of addr 0..15 all return clear_value_p with rd_valid_o one cycle after each accept.
- Write 0xDEADBEEF to addr 5 with mask 4'b1111, then write 0x11223344 to addr 5 with mask 4'b0101, then read 5 -> 0xDE22BE44.
- Same-cycle write 0xAAAAAAAA (mask 4'b0011) and read at addr 3, which holds 0x12345678 -> next-cycle rd_data_o=0x1234AAAA. A same-cycle read of addr 4 returns the old contents of addr 4.
- Write 0xCAFEF00D to addr 9 in the same cycle clear_i=1 is sampled -> write accepted, busy_o high for 16 cycles, then a read of addr 9 returns clear_value_p.
- depth_p=12: write 0x5 to addr 13 -> accepted, no entry changes; read addr 13 -> rd_valid_o=1, rd_data_o=clear_value_p.
- Reset asserted at clear cycle 7 -> busy_o stays high and the pass restarts at addr 0. With RAM_OUT_REG_EN, a read accepted at N gives rd_valid_o at N+2 only.
